// File: rtl/sample_uart_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : sample_uart_pkg
// Brief  : Shared states, frame constants and byte builder for the sample
//          UART scheduler.
// Rev    : 1.0
// ============================================================================
package sample_uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    localparam int          FRAME_BYTES  = 20;
    localparam int          BYTES_PER_CH = 5;
    localparam logic [7:0]  ASCII_C      = 8'h43;
    localparam logic [7:0]  ASCII_H      = 8'h48;
    localparam logic [7:0]  ASCII_0      = 8'h30;
    localparam int          BUSY_TIMEOUT = 4;

    // Per-channel record: 'C' 'H' '0'+ch MSB LSB
    function automatic logic [7:0] frame_byte(input logic [1:0]  ch,
                                              input logic [2:0]  field,
                                              input logic [15:0] samp);
        logic [7:0] b;
        case (field)
            3'd0:    b = ASCII_C;
            3'd1:    b = ASCII_H;
            3'd2:    b = ASCII_0 + {6'd0, ch};
            3'd3:    b = samp[15:8];
            default: b = samp[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_uart_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : sample_uart_scheduler_if
// Brief  : Byte handshake between the scheduler (master) and uart_tx (slave).
// Rev    : 1.0
// ============================================================================
interface sample_uart_scheduler_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface
`default_nettype wire

// File: rtl/sample_uart_scheduler_edge_sync.sv
`default_nettype none
// ============================================================================
// Module : edge_sync
// Brief  : Two-flop synchroniser with a rising-edge pulse from a third flop.
// Rev    : 1.0
// ============================================================================
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/sample_uart_scheduler.sv
`default_nettype none
// ============================================================================
// Module : sample_uart_scheduler
// Brief  : Decimates codec sample strobes, snapshots four channels and streams
//          one 20-byte telemetry frame through uart_tx.
// Rev    : 1.0
// ============================================================================
module sample_uart_scheduler
    import sample_uart_pkg::*;
#(
    parameter int DECIMATE = 4800
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic signed [15:0]  sample_in0,
    input  logic signed [15:0]  sample_in1,
    input  logic signed [15:0]  sample_in2,
    input  logic signed [15:0]  sample_in3,
    input  logic                enable,
    sample_uart_scheduler_if.master uart,
    output logic                frame_done,
    output logic [7:0]          drop_count,
    output logic                active
);
    localparam logic [15:0] c_dec_last   = 16'(DECIMATE - 1);
    localparam logic [2:0]  c_last_field = 3'(BYTES_PER_CH - 1);
    localparam logic [1:0]  c_last_ch    = 2'(FRAME_BYTES / BYTES_PER_CH - 1);
    localparam logic [2:0]  c_wait_last  = 3'(BUSY_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_edge;
    logic        w_snap_req;
    logic        w_take_snap;
    logic        w_frame_end;
    logic        w_advance;
    logic        w_last_byte;
    logic [15:0] r_dec_cnt;
    logic [15:0] r_samp [4];
    logic [1:0]  r_ch;
    logic [2:0]  r_field;
    logic [2:0]  r_wait_cnt;
    logic [7:0]  r_tx_data;
    logic        r_active;
    logic [7:0]  r_drop;

    edge_sync u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (sample_clk),
        .o_rise  (w_edge)
    );

    assign w_snap_req  = w_edge && enable && (r_dec_cnt == c_dec_last);
    assign w_take_snap = w_snap_req && (r_state == IDLE);
    assign w_last_byte = (r_ch == c_last_ch) && (r_field == c_last_field);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_cnt <= '0;
        end else if (w_edge && enable) begin
            r_dec_cnt <= (r_dec_cnt == c_dec_last) ? 16'd0 : r_dec_cnt + 16'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_end  = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE:    if (w_snap_req) w_state_next = LOAD;
            LOAD:    if (!uart.tx_busy) w_state_next = START;
            START:   w_state_next = WAIT_HI;
            // Give up waiting for busy after the timeout so a lost start cannot hang the frame
            WAIT_HI: if (uart.tx_busy || (r_wait_cnt == c_wait_last)) w_state_next = WAIT_LO;
            WAIT_LO: begin
                if (!uart.tx_busy) begin
                    if (w_last_byte) begin
                        w_frame_end  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = LOAD;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_samp[i] <= '0;
            r_ch       <= '0;
            r_field    <= '0;
            r_wait_cnt <= '0;
            r_tx_data  <= '0;
            r_active   <= 1'b0;
            r_drop     <= '0;
        end else begin
            if (w_take_snap) begin
                r_samp[0] <= sample_in0;
                r_samp[1] <= sample_in1;
                r_samp[2] <= sample_in2;
                r_samp[3] <= sample_in3;
            end
            if (w_take_snap)      r_active <= 1'b1;
            else if (w_frame_end) r_active <= 1'b0;
            if (w_snap_req && (r_state != IDLE) && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
            if (r_state == LOAD) r_tx_data <= frame_byte(r_ch, r_field, r_samp[r_ch]);
            r_wait_cnt <= (r_state == WAIT_HI) ? r_wait_cnt + 3'd1 : 3'd0;
            if (w_frame_end) begin
                r_ch    <= '0;
                r_field <= '0;
            end else if (w_advance) begin
                if (r_field == c_last_field) begin
                    r_field <= '0;
                    r_ch    <= r_ch + 2'd1;
                end else begin
                    r_field <= r_field + 3'd1;
                end
            end
        end
    end

    assign uart.tx_start = (r_state == START) && !rst;
    assign uart.tx_data  = r_tx_data;
    assign frame_done    = w_frame_end && !rst;
    assign drop_count    = r_drop;
    assign active        = r_active;
endmodule
`default_nettype wire

// File: tb/tb_sample_uart_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_sample_uart_scheduler
// Brief  : Directed bench for the sample UART scheduler with uart_tx models.
// Rev    : 1.0
// ============================================================================
module tb_sample_uart_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        sclk_a, sclk_b, en_a, en_b, nobusy_a;
    logic [15:0] s0, s1, s2, s3;
    logic        done_a, done_b, act_a, act_b;
    logic [7:0]  drop_a, drop_b;
    int          busy_a = 0, busy_b = 0;
    int          starts_a = 0, done_cnt_a = 0;
    int          checks = 0, errors = 0;
    logic [7:0]  q_a [$];

    logic [7:0] exp1 [20] = '{8'h43, 8'h48, 8'h30, 8'h12, 8'h34,
                              8'h43, 8'h48, 8'h31, 8'hAB, 8'hCD,
                              8'h43, 8'h48, 8'h32, 8'h80, 8'h00,
                              8'h43, 8'h48, 8'h33, 8'h7F, 8'hFF};
    logic [7:0] exp2 [20] = '{8'h43, 8'h48, 8'h30, 8'h00, 8'h01,
                              8'h43, 8'h48, 8'h31, 8'h00, 8'h01,
                              8'h43, 8'h48, 8'h32, 8'h00, 8'h01,
                              8'h43, 8'h48, 8'h33, 8'h00, 8'h01};

    always #5 clk = ~clk;

    sample_uart_scheduler_if ua ();
    sample_uart_scheduler_if ub ();

    sample_uart_scheduler #(.DECIMATE(2)) dut_a (
        .clk(clk), .rst(rst), .sample_clk(sclk_a),
        .sample_in0(s0), .sample_in1(s1), .sample_in2(s2), .sample_in3(s3),
        .enable(en_a), .uart(ua.master), .frame_done(done_a),
        .drop_count(drop_a), .active(act_a)
    );

    sample_uart_scheduler #(.DECIMATE(1)) dut_b (
        .clk(clk), .rst(rst), .sample_clk(sclk_b),
        .sample_in0(s0), .sample_in1(s1), .sample_in2(s2), .sample_in3(s3),
        .enable(en_b), .uart(ub.master), .frame_done(done_b),
        .drop_count(drop_b), .active(act_b)
    );

    // uart_tx models: busy rises the cycle after tx_start
    always @(posedge clk) begin
        if (rst)                          busy_a <= 0;
        else if (ua.tx_start && !nobusy_a) busy_a <= 10;
        else if (busy_a != 0)             busy_a <= busy_a - 1;
        if (rst)               busy_b <= 0;
        else if (ub.tx_start)  busy_b <= 200;
        else if (busy_b != 0)  busy_b <= busy_b - 1;
    end
    assign ua.tx_busy = (busy_a != 0);
    assign ub.tx_busy = (busy_b != 0);

    always @(negedge clk) begin
        if (ua.tx_start) begin
            q_a.push_back(ua.tx_data);
            starts_a++;
        end
        if (done_a) done_cnt_a++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_a();
        sclk_a = 1'b1;
        tick(4);
        sclk_a = 1'b0;
        tick(4);
    endtask

    task automatic wait_done_a(input int target, input int bound);
        int n;
        n = 0;
        while (done_cnt_a < target && n < bound) begin
            tick(1);
            n++;
        end
        chk("frame_done_timeout", 32'(done_cnt_a >= target), 32'd1);
    endtask

    task automatic chk_frame(input logic [7:0] e [20]);
        logic [7:0] got;
        chk("frame_len", 32'(q_a.size()), 32'd20);
        for (int i = 0; i < 20; i++) begin
            got = (i < q_a.size()) ? q_a[i] : 8'hxx;
            chk($sformatf("byte%0d", i), {24'd0, got}, {24'd0, e[i]});
        end
    endtask

    initial begin
        int n;
        int st0;
        int dbase;
        rst = 1'b1; sclk_a = 1'b0; sclk_b = 1'b0; en_a = 1'b1; en_b = 1'b1; nobusy_a = 1'b0;
        s0 = 16'h1234; s1 = 16'hABCD; s2 = 16'h8000; s3 = 16'h7FFF;
        tick(3);
        chk("rst_tx_start", 32'(ua.tx_start), 32'd0);
        chk("rst_tx_data", 32'(ua.tx_data), 32'd0);
        chk("rst_frame_done", 32'(done_a), 32'd0);
        chk("rst_drop", 32'(drop_a), 32'd0);
        chk("rst_active", 32'(act_a), 32'd0);
        rst = 1'b0;
        tick(2);

        // Frame 1: two edges at DECIMATE=2, inputs change after the snapshot
        pulse_a();
        chk("no_snap_first_edge", 32'(act_a), 32'd0);
        pulse_a();
        chk("snap_second_edge", 32'(act_a), 32'd1);
        s0 = 16'h0001; s1 = 16'h0001; s2 = 16'h0001; s3 = 16'h0001;
        wait_done_a(1, 2000);
        tick(1);
        chk_frame(exp1);
        chk("done_count_1", 32'(done_cnt_a), 32'd1);
        chk("drop_frame1", 32'(drop_a), 32'd0);
        chk("active_cleared", 32'(act_a), 32'd0);

        // Frame 2 carries the new inputs
        q_a.delete();
        pulse_a();
        pulse_a();
        wait_done_a(2, 2000);
        tick(1);
        chk_frame(exp2);
        chk("drop_frame2", 32'(drop_a), 32'd0);

        // Counter holds while disabled
        pulse_a();
        chk("one_edge_counted", 32'(act_a), 32'd0);
        en_a = 1'b0;
        st0 = starts_a;
        repeat (11) pulse_a();
        chk("no_start_disabled", 32'(starts_a - st0), 32'd0);
        chk("inactive_disabled", 32'(act_a), 32'd0);
        en_a = 1'b1;
        pulse_a();
        chk("snap_after_enable", 32'(act_a), 32'd1);
        wait_done_a(3, 2000);
        tick(1);

        // Drop during a frame, then reset mid-frame
        q_a.delete();
        dbase = done_cnt_a;
        pulse_a();
        pulse_a();
        pulse_a();
        pulse_a();
        chk("drop_in_flight", 32'(drop_a), 32'd1);
        n = 0;
        while (q_a.size() < 7 && n < 1000) begin
            tick(1);
            n++;
        end
        chk("reach_byte7", 32'(q_a.size() >= 7), 32'd1);
        rst = 1'b1;
        chk("tx_start_in_rst", 32'(ua.tx_start), 32'd0);
        tick(1);
        chk("midrst_tx_start", 32'(ua.tx_start), 32'd0);
        chk("midrst_active", 32'(act_a), 32'd0);
        chk("midrst_drop", 32'(drop_a), 32'd0);
        chk("midrst_tx_data", 32'(ua.tx_data), 32'd0);
        rst = 1'b0;
        tick(1);
        q_a.delete();
        pulse_a();
        pulse_a();
        n = 0;
        while (q_a.size() < 1 && n < 100) begin
            tick(1);
            n++;
        end
        chk("restart_byte0", 32'((q_a.size() > 0) ? q_a[0] : 8'hxx), 32'h43);
        wait_done_a(dbase + 1, 2000);
        tick(1);
        chk_frame(exp2);

        // Lost-start guard: uart never goes busy
        nobusy_a = 1'b1;
        pulse_a();
        sclk_a = 1'b1;
        n = 0;
        while (!act_a && n < 20) begin
            tick(1);
            n++;
        end
        chk("timeout_snap", 32'(act_a), 32'd1);
        n = 1;
        while (!done_a && n < 1000) begin
            tick(1);
            n++;
        end
        chk("timeout_frame_cycles", 32'(n), 32'd140);
        sclk_a = 1'b0;
        tick(2);
        nobusy_a = 1'b0;

        // DECIMATE=1 with a slow uart: one drop per edge, saturating
        for (int e = 0; e < 330; e++) begin
            sclk_b = 1'b1;
            tick(10);
            if (e == 0) begin
                chk("b_snap", 32'(act_b), 32'd1);
                chk("b_drop0", 32'(drop_b), 32'd0);
            end
            if (e == 1) chk("b_drop1", 32'(drop_b), 32'd1);
            if (e == 2) chk("b_drop2", 32'(drop_b), 32'd2);
            tick(40);
            sclk_b = 1'b0;
            tick(50);
        end
        chk("b_drop_saturated", 32'(drop_b), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
